// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the sequence-detector front end and the Moore FSM
// it feeds.
//   DEBOUNCE_CYCLES_DEF : default stable-cycle count (20 ms at 50 MHz)
//   TICK_CYCLES_DEF     : default clocks per step_tick (1 s at 50 MHz)
//   KEY_PRESSED         : level of the active-low push-button when pressed
//   state_t             : 3-bit state encoding shared with the downstream FSM
package moore_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned TICK_CYCLES_DEF     = 50_000_000;

  localparam logic KEY_PRESSED = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_MATCH = 3'd4
  } state_t;

endpackage : moore_pkg

// File: rtl/input_conditioner_if.sv
// Board-side signal bundle of the input conditioner.
//   in_raw, key_pause_n : raw asynchronous inputs (switch, active-low button)
//   in_clean            : debounced switch level
//   pause               : latched pause state
//   step_tick           : single-cycle FSM advance strobe
// master drives the raw inputs and observes the results; slave is the
// conditioner itself.
interface input_conditioner_if;

  logic in_raw;
  logic key_pause_n;
  logic in_clean;
  logic pause;
  logic step_tick;

  modport master (
    output in_raw,
    output key_pause_n,
    input  in_clean,
    input  pause,
    input  step_tick
  );

  modport slave (
    input  in_raw,
    input  key_pause_n,
    output in_clean,
    output pause,
    output step_tick
  );

endinterface : input_conditioner_if

// File: rtl/input_conditioner_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   raw   : asynchronous, bouncy input
//   level : synchronised level, updated only after CYCLES consecutive
//           cycles of disagreement with the current stable value
// Parameters: CYCLES (>= 2), RESET_LEVEL (reset value of every flop).
module debounce
  import moore_pkg::*;
#(
  parameter int unsigned CYCLES      = DEBOUNCE_CYCLES_DEF,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned     CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_LEVEL;
      sync <= RESET_LEVEL;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Any sample that agrees with the stable value restarts the count, so a
  // glitch shorter than CYCLES never gets through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= RESET_LEVEL;
      cnt    <= '0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level = stable;

endmodule : debounce

// File: rtl/input_conditioner.sv
// Front end of the sequence-detector Moore machine.
//   clk : 50 MHz system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : input_conditioner_if.slave
//         in_raw/key_pause_n in; in_clean/pause/step_tick out
// Debounces the slide switch and pause button, toggles pause once per
// debounced press, and emits a one-cycle step_tick every TICK_CYCLES clocks
// while not paused. The tick counter freezes during pause and resumes from
// where it stopped.
module input_conditioner
  import moore_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TICK_CYCLES     = TICK_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input_conditioner_if.slave  bus
);

  localparam int unsigned   TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic          in_db;
  logic          key_db;
  logic          key_prev;
  logic          press;
  logic          pause_q;
  logic          tick_q;
  logic [TW-1:0] t;

  debounce #(
    .CYCLES      (DEBOUNCE_CYCLES),
    .RESET_LEVEL (1'b0)
  ) u_in_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.in_raw),
    .level (in_db)
  );

  debounce #(
    .CYCLES      (DEBOUNCE_CYCLES),
    .RESET_LEVEL (~KEY_PRESSED)
  ) u_key_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.key_pause_n),
    .level (key_db)
  );

  // Falling edge of the debounced key; releases and holds do nothing.
  always_comb begin
    press = (key_prev != KEY_PRESSED) && (key_db == KEY_PRESSED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_prev <= ~KEY_PRESSED;
      pause_q  <= 1'b0;
    end else begin
      key_prev <= key_db;
      if (press) begin
        pause_q <= ~pause_q;
      end
    end
  end

  // Uses the pre-toggle pause value, so a press landing on the terminal
  // count still lets that tick out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t      <= '0;
      tick_q <= 1'b0;
    end else if (pause_q) begin
      tick_q <= 1'b0;
    end else if (t == TICK_LAST) begin
      t      <= '0;
      tick_q <= 1'b1;
    end else begin
      t      <= t + TW'(1);
      tick_q <= 1'b0;
    end
  end

  assign bus.in_clean  = in_db;
  assign bus.pause     = pause_q;
  assign bus.step_tick = tick_q;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  logic clk;
  logic rst;
  int unsigned n_cmp;
  int unsigned n_err;
  int          edge_n;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .TICK_CYCLES     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b0;
    bus.in_raw      = 1'b0;
    bus.key_pause_n = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    edge_n          = 0;
    rst             = 1'b0;
    bus.in_raw      = 1'b0;
    bus.key_pause_n = 1'b1;

    // 1: reset values and free-running tick
    repeat (2) @(negedge clk);
    check_eq("rst_in_clean", {31'd0, bus.in_clean}, 32'd0);
    check_eq("rst_pause", {31'd0, bus.pause}, 32'd0);
    check_eq("rst_tick", {31'd0, bus.step_tick}, 32'd0);
    rst    = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      check_eq($sformatf("free_tick@%0d", edge_n), {31'd0, bus.step_tick},
               {31'd0, (edge_n % 8) == 0});
      check_eq($sformatf("free_pause@%0d", edge_n), {31'd0, bus.pause}, 32'd0);
    end

    // 2: bounce rejection; final stable change before edge 5, accept on edge 10
    do_reset();
    bus.in_raw = 1'b1;
    cyc(); cyc();
    bus.in_raw = 1'b0;
    cyc(); cyc();
    bus.in_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check_eq($sformatf("bounce_in_clean@%0d", edge_n), {31'd0, bus.in_clean},
               {31'd0, edge_n >= 10});
    end

    // 3: pause press / hold / release, second press resumes frozen count
    do_reset();
    bus.key_pause_n = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (edge_n == 20) bus.key_pause_n = 1'b1;
      if (edge_n == 30) bus.key_pause_n = 1'b0;
      if (edge_n == 40) bus.key_pause_n = 1'b1;
      check_eq($sformatf("press_pause@%0d", edge_n), {31'd0, bus.pause},
               {31'd0, (edge_n >= 7) && (edge_n < 37)});
      check_eq($sformatf("press_tick@%0d", edge_n), {31'd0, bus.step_tick},
               {31'd0, (edge_n == 38) || (edge_n == 46)});
    end

    // 4: pause toggles on edge 8, where t=7: that tick still fires
    do_reset();
    cyc();
    bus.key_pause_n = 1'b0;
    for (int i = 0; i < 29; i++) begin
      cyc();
      check_eq($sformatf("coll_tick@%0d", edge_n), {31'd0, bus.step_tick},
               {31'd0, edge_n == 8});
      check_eq($sformatf("coll_pause@%0d", edge_n), {31'd0, bus.pause},
               {31'd0, edge_n >= 8});
    end

    // 5: 3-cycle low glitches never toggle pause
    do_reset();
    for (int p = 0; p < 4; p++) begin
      bus.key_pause_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (i == 3) bus.key_pause_n = 1'b1;
        cyc();
        check_eq($sformatf("glitch_pause@%0d", edge_n), {31'd0, bus.pause}, 32'd0);
        check_eq($sformatf("glitch_tick@%0d", edge_n), {31'd0, bus.step_tick},
                 {31'd0, (edge_n % 8) == 0});
      end
    end

    // 6: reset with key counter at 2 (after edge 4), key released during reset
    do_reset();
    bus.key_pause_n = 1'b0;
    repeat (4) cyc();
    rst = 1'b0;
    #1;
    check_eq("midrst_pause", {31'd0, bus.pause}, 32'd0);
    check_eq("midrst_tick", {31'd0, bus.step_tick}, 32'd0);
    bus.key_pause_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_eq($sformatf("midrst_pause@%0d", edge_n), {31'd0, bus.pause}, 32'd0);
      check_eq($sformatf("midrst_tick@%0d", edge_n), {31'd0, bus.step_tick},
               {31'd0, (edge_n % 8) == 0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_input_conditioner
